// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the shift arbiter: widths, op encodings, requester IDs, bit helpers.
// Optional round-robin tie-break is selected with SHIFT_ARB_RR_EN (see shift_arbiter.sv).
package shift_pkg;

    localparam int W       = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] SHIFT_SLL  = 2'b00;
    localparam logic [1:0] SHIFT_SRL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b10;
    localparam logic [1:0] SHIFT_PASS = 2'b11;

    localparam logic REQ_MD  = 1'b0;
    localparam logic REQ_ALU = 1'b1;

    function automatic logic [W-1:0] bit_reverse(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        return r;
    endfunction

    function automatic logic [1:0] onehot2(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters (master) and the shift arbiter (slave).
// Handshake: a request or response transfers on a rising edge where its valid and ready are both high.
interface shift_arbiter_if;

    logic [1:0]                  req_valid;
    logic [1:0]                  req_ready;
    logic [shift_pkg::W-1:0]     req_data0;
    logic [shift_pkg::W-1:0]     req_data1;
    logic [shift_pkg::SHAMT_W-1:0] req_shamt0;
    logic [shift_pkg::SHAMT_W-1:0] req_shamt1;
    logic [1:0]                  req_op0;
    logic [1:0]                  req_op1;
    logic [1:0]                  rsp_valid;
    logic [1:0]                  rsp_ready;
    logic [shift_pkg::W-1:0]     rsp_data;
    logic                        busy;

    modport master (
        output req_valid, req_data0, req_data1, req_shamt0, req_shamt1, req_op0, req_op1,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_data0, req_data1, req_shamt0, req_shamt1, req_op0, req_op1,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/shift_arbiter_core.sv
// Combinational 5-stage logarithmic shifter; left shifts reuse the right-shift
// network by reversing the operand on the way in and the result on the way out.
module shift_core
    import shift_pkg::*;
(
    input  logic [W-1:0]       data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic [W-1:0]       result
);

    logic           left;
    logic           fill;
    logic [W-1:0]   stage [SHAMT_W+1];

    assign left     = (op == SHIFT_SLL);
    assign fill     = (op == SHIFT_SRA) & data[W-1];
    assign stage[0] = left ? bit_reverse(data) : data;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int S = 1 << i;
        assign stage[i+1] = shamt[i] ? {{S{fill}}, stage[i][W-1:S]} : stage[i];
    end

    always_comb begin
        result = data;
        case (op)
            SHIFT_SLL: result = bit_reverse(stage[SHAMT_W]);
            SHIFT_SRL,
            SHIFT_SRA: result = stage[SHAMT_W];
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of one shared shifter with a single registered result slot.
// Ties go to port 0 unless SHIFT_ARB_RR_EN is defined, which enables round-robin.
module shift_arbiter
    import shift_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    shift_arbiter_if.slave bus,
    output logic [1:0]     slot_state
);

    // Slot encoding doubles as the one-hot rsp_valid vector.
    localparam logic [1:0] SLOT_EMPTY    = 2'b00;
    localparam logic [1:0] SLOT_FULL_MD  = 2'b01;
    localparam logic [1:0] SLOT_FULL_ALU = 2'b10;

    logic [1:0]         state;
    logic [W-1:0]       data_q;
    logic               grant;
    logic               any_valid;
    logic               owner_ready;
    logic               slot_free;
    logic               accept;
    logic [W-1:0]       sel_data;
    logic [SHAMT_W-1:0] sel_shamt;
    logic [1:0]         sel_op;
    logic [W-1:0]       result;

`ifdef SHIFT_ARB_RR_EN
    logic               last_grant;
`endif

    assign any_valid   = |bus.req_valid;
    assign owner_ready = |(state & bus.rsp_ready);
    assign slot_free   = (state == SLOT_EMPTY) | owner_ready;
    assign accept      = any_valid & slot_free;

    always_comb begin
        grant = REQ_MD;
        if (bus.req_valid == 2'b10) begin
            grant = REQ_ALU;
        end
`ifdef SHIFT_ARB_RR_EN
        else if (bus.req_valid == 2'b11) begin
            grant = (last_grant == REQ_MD) ? REQ_ALU : REQ_MD;
        end
`endif
    end

    assign sel_data  = grant ? bus.req_data1  : bus.req_data0;
    assign sel_shamt = grant ? bus.req_shamt1 : bus.req_shamt0;
    assign sel_op    = grant ? bus.req_op1    : bus.req_op0;

    shift_core u_core (
        .data   (sel_data),
        .shamt  (sel_shamt),
        .op     (sel_op),
        .result (result)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= SLOT_EMPTY;
            data_q <= '0;
        end else if (accept) begin
            state  <= onehot2(grant);
            data_q <= result;
        end else if (owner_ready) begin
            state  <= SLOT_EMPTY;
        end
    end

`ifdef SHIFT_ARB_RR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= REQ_ALU;
        end else if (accept) begin
            last_grant <= grant;
        end
    end
`endif

    assign bus.req_ready = accept ? onehot2(grant) : 2'b00;
    assign bus.rsp_valid = state;
    assign bus.rsp_data  = data_q;
    assign bus.busy      = (state != SLOT_EMPTY);
    assign slot_state    = state;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed vectors with literal results plus a per-cycle
// transaction-level model; honours SHIFT_ARB_RR_EN for the tie-break expectation.
module tb_shift_arbiter;

    localparam int W = 32;

    logic clock;
    logic reset;
    logic [1:0] slot_state;

    int n_checks = 0;
    int n_fail   = 0;

    shift_arbiter_if bus ();

    shift_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .slot_state (slot_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [4:0] sh,
                                               input logic [1:0] op);
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return $unsigned($signed(d) >>> sh);
            default: return d;
        endcase
    endfunction

    logic [W-1:0] exp_q[$];
    logic         m_valid = 1'b0;
    logic         m_owner = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_last  = 1;

    always @(negedge clock) begin
        int g;
        logic free;
        logic [1:0] exp_rv, exp_rr;
        if (!reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_last  = 1;
            exp_q.delete();
            chk("model_reset_rsp_valid", bus.rsp_valid, 2'b00);
            chk("model_reset_busy", bus.busy, 1'b0);
        end else begin
            exp_rv = m_valid ? (2'b01 << m_owner) : 2'b00;
            chk("model_rsp_valid", bus.rsp_valid, exp_rv);
            chk("model_busy", bus.busy, m_valid);
            chk("model_rsp_data", bus.rsp_data, m_data);
            chk("model_onehot", ($countones(bus.rsp_valid) <= 1), 1'b1);
            free = !m_valid || bus.rsp_ready[m_owner];
            if (bus.req_valid == 2'b10) g = 1;
            else if (bus.req_valid == 2'b11) begin
`ifdef SHIFT_ARB_RR_EN
                g = (m_last == 0) ? 1 : 0;
`else
                g = 0;
`endif
            end else g = 0;
            exp_rr = (bus.req_valid != 2'b00 && free) ? (2'b01 << g) : 2'b00;
            chk("model_req_ready", bus.req_ready, exp_rr);
            // Scoreboard: consumed responses must come out in order, once each.
            if (m_valid && bus.rsp_ready[m_owner]) begin
                if (exp_q.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
                else chk("sb_consumed_data", bus.rsp_data, exp_q.pop_front());
                m_valid = 1'b0;
            end
            if (bus.req_valid != 2'b00 && free) begin
                m_data = (g == 1) ? ref_shift(bus.req_data1, bus.req_shamt1, bus.req_op1)
                                  : ref_shift(bus.req_data0, bus.req_shamt0, bus.req_op0);
                m_valid = 1'b1;
                m_owner = g[0];
                m_last  = g;
                exp_q.push_back(m_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.req_valid  = 2'b00;
        bus.req_data0  = '0;
        bus.req_data1  = '0;
        bus.req_shamt0 = '0;
        bus.req_shamt1 = '0;
        bus.req_op0    = 2'b00;
        bus.req_op1    = 2'b00;
        bus.rsp_ready  = 2'b11;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Starts and ends 1 time unit after a rising edge with the slot empty.
    task automatic do_shift(input string name, input logic [W-1:0] d, input logic [4:0] sh,
                            input logic [1:0] op, input logic [W-1:0] exp);
        bus.req_valid  = 2'b01;
        bus.req_data0  = d;
        bus.req_shamt0 = sh;
        bus.req_op0    = op;
        bus.rsp_ready  = 2'b11;
        @(negedge clock);
        chk({name, "_req_ready"}, bus.req_ready, 2'b01);
        @(posedge clock); #1;
        bus.req_valid = 2'b00;
        @(negedge clock);
        chk({name, "_rsp_valid"}, bus.rsp_valid, 2'b01);
        chk({name, "_rsp_data"}, bus.rsp_data, exp);
        @(posedge clock); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] rdy_s;
        do_reset();
        @(negedge clock);
        chk("reset_rsp_valid", bus.rsp_valid, 2'b00);
        chk("reset_rsp_data", bus.rsp_data, 32'h0);
        chk("reset_busy", bus.busy, 1'b0);
        @(posedge clock); #1;

        do_shift("sra_neg_4",   32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000);
        do_shift("srl_31",      32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
        do_shift("sll_31",      32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
        do_shift("shamt0",      32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF);
        do_shift("pass_7",      32'h1234_5678, 5'd7,  2'b11, 32'h1234_5678);
        do_shift("sra_pos_31",  32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000);
        do_shift("sll_8",       32'h00AB_CDEF, 5'd8,  2'b00, 32'hABCD_EF00);

        // Tie after reset
        do_reset();
        @(posedge clock); #1;
        bus.req_valid  = 2'b11;
        bus.req_data0  = 32'h0000_00F0; bus.req_shamt0 = 5'd4; bus.req_op0 = 2'b01;
        bus.req_data1  = 32'h0000_000F; bus.req_shamt1 = 5'd4; bus.req_op1 = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
`ifdef SHIFT_ARB_RR_EN
            chk("tie_grant", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
            chk("tie_grant", bus.req_ready, 2'b01);
`endif
            if (i > 0) begin
`ifdef SHIFT_ARB_RR_EN
                chk("tie_result", bus.rsp_data, (i % 2 == 1) ? 32'h0000_000F : 32'h0000_00F0);
`else
                chk("tie_result", bus.rsp_data, 32'h0000_000F);
`endif
            end
            @(posedge clock); #1;
        end
        bus.req_valid = 2'b00;
        @(posedge clock); #1;

        // Backpressure on port 1, non-owner ready ignored, refill without bubble
        bus.req_valid  = 2'b10;
        bus.req_data1  = 32'h0000_F00F; bus.req_shamt1 = 5'd4; bus.req_op1 = 2'b00;
        bus.rsp_ready  = 2'b00;
        @(negedge clock);
        chk("bp_accept", bus.req_ready, 2'b10);
        @(posedge clock); #1;
        bus.req_valid  = 2'b01;
        bus.req_data0  = 32'h1234_5678; bus.req_shamt0 = 5'd8; bus.req_op0 = 2'b01;
        bus.rsp_ready  = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_req_ready", bus.req_ready, 2'b00);
            chk("bp_rsp_valid", bus.rsp_valid, 2'b10);
            chk("bp_rsp_data", bus.rsp_data, 32'h000F_00F0);
            @(posedge clock); #1;
        end
        bus.rsp_ready = 2'b10;
        @(negedge clock);
        chk("bp_refill_ready", bus.req_ready, 2'b01);
        @(posedge clock); #1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        @(negedge clock);
        chk("bp_refill_valid", bus.rsp_valid, 2'b01);
        chk("bp_refill_data", bus.rsp_data, 32'h0012_3456);
        @(posedge clock); #1;

        // Reset while FULL
        bus.req_valid = 2'b10;
        bus.req_data1 = 32'hAAAA_0000; bus.req_op1 = 2'b11;
        bus.rsp_ready = 2'b00;
        @(posedge clock); #1;
        bus.req_valid = 2'b00;
        @(negedge clock);
        chk("rst_mid_full", bus.busy, 1'b1);
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rst_mid_busy", bus.busy, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        @(negedge clock);
        chk("rst_mid_first_tie", bus.req_ready, 2'b01);
        @(posedge clock); #1;
        bus.req_valid = 2'b00;
        @(posedge clock); #1;

        // Random stress with hold-while-stalled requesters
        rdy_s = 2'b00;
        for (int n = 0; n < 600; n++) begin
            if (!(bus.req_valid[0] && !rdy_s[0])) begin
                bus.req_valid[0] = ($urandom_range(0, 2) != 0);
                bus.req_data0    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                bus.req_shamt0   = 5'($urandom_range(0, 31));
                bus.req_op0      = 2'($urandom_range(0, 3));
            end
            if (!(bus.req_valid[1] && !rdy_s[1])) begin
                bus.req_valid[1] = ($urandom_range(0, 2) != 0);
                bus.req_data1    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                bus.req_shamt1   = 5'($urandom_range(0, 31));
                bus.req_op1      = 2'($urandom_range(0, 3));
            end
            bus.rsp_ready = 2'($urandom_range(0, 3));
            @(negedge clock);
            rdy_s = bus.req_ready;
            @(posedge clock); #1;
        end

        idle_inputs();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
